// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the frequency meter.
// Defaults describe the production DDS build: 23-bit accumulator, 16-bit tuning word.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } fm_state_e;

    localparam int DEF_N         = 23;
    localparam int DEF_TUNE      = 16;
    localparam int DEF_GATE_LOG2 = 19;

    function automatic int shift_of(input int acc_w, input int g_log2);
        return acc_w - g_log2;
    endfunction

    // The gate must be at least 2 cycles and must not exceed the accumulator scale.
    function automatic bit gate_cfg_ok(input int acc_w, input int g_log2);
        return (g_log2 >= 1) && (g_log2 <= acc_w);
    endfunction

    localparam int SHIFT      = shift_of(DEF_N, DEF_GATE_LOG2);
    localparam int GATE_MAX   = 2 ** DEF_GATE_LOG2;
    localparam bit DEF_CFG_OK = gate_cfg_ok(DEF_N, DEF_GATE_LOG2);

endpackage

// File: rtl/freq_meter_if.sv
// Control and result signals of the frequency meter, grouped for a single port.
// Handshake: start is a one-cycle request honoured only while idle with ce high;
// valid is a one-cycle pulse, and tuning_out/overflow hold their value until the next valid.
interface freq_meter_if #(
    parameter int tune = 16
);
    logic            ce;
    logic            sig_in;
    logic            start;
    logic            busy;
    logic            valid;
    logic [tune-1:0] tuning_out;
    logic            overflow;

    modport master (
        output ce, sig_in, start,
        input  busy, valid, tuning_out, overflow
    );

    modport slave (
        input  ce, sig_in, start,
        output busy, valid, tuning_out, overflow
    );
endinterface

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: two-flop synchronizer plus registered rise detector for an asynchronous pin.
// rise is high for one cycle, three clock edges after the pin goes high.
module freq_meter_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [1:0] sync;
    logic       sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync   <= {sync[0], d};
            sync_d <= sync[1];
            rise   <= sync[1] & ~sync_d;
        end
    end
endmodule

// File: rtl/freq_meter.sv
// Gated edge-count frequency meter: reports f_in * 2^n / f_clk as a DDS tuning word.
// The gate is 2^gate_log2 cycles, so scaling to accumulator units is a plain left shift.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int n         = DEF_N,
    parameter int tune      = DEF_TUNE,
    parameter int gate_log2 = DEF_GATE_LOG2
) (
    input  logic        clk,
    input  logic        rst_n,
    freq_meter_if.slave bus,
    output fm_state_e   dbg_state
);
    localparam int shift_amt = shift_of(n, gate_log2);
    localparam int calc_w    = ((n > tune) ? n : tune) + 1;
    localparam logic [gate_log2-1:0] cnt_one  = gate_log2'(1);
    localparam logic [gate_log2-1:0] gate_end_val = '1;

    if (!gate_cfg_ok(n, gate_log2)) begin : g_cfg_check
        $error("freq_meter: gate_log2 must be in 1..n");
    end

    fm_state_e            state;
    fm_state_e            state_nx;
    logic [gate_log2-1:0] gate_cnt;
    logic [gate_log2-1:0] edge_cnt;
    logic                 no_edge;
    logic                 rise;
    logic                 gate_end;
    logic                 busy;
    logic                 valid_q;
    logic                 overflow_q;
    logic [tune-1:0]      tuning_q;
    logic [calc_w-1:0]    scaled;
    logic                 sat;

    freq_meter_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sig_in),
        .rise  (rise)
    );

    // Last gate cycle: in ALIGN this is the timeout, in COUNT the gate close.
    assign gate_end = (gate_cnt == gate_end_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!bus.ce) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nx = ALIGN;
                ALIGN: begin
                    if (rise)          state_nx = COUNT;
                    else if (gate_end) state_nx = DONE;
                end
                COUNT:   if (gate_end) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // DONE counts as busy: busy drops exactly when the result is published.
    always_comb begin
        busy = 1'b0;
        case (state)
            ALIGN, COUNT, DONE: busy = 1'b1;
            default:            busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            no_edge  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    no_edge  <= 1'b0;
                end
                ALIGN: begin
                    if (rise) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + cnt_one;
                        no_edge  <= gate_end;
                    end
                end
                COUNT: begin
                    gate_cnt <= gate_cnt + cnt_one;
                    if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + cnt_one;
                end
                default: ;
            endcase
        end
    end

    // Anything shifted above bit tune-1 means the word cannot represent the rate.
    assign scaled = calc_w'(edge_cnt) << shift_amt;
    assign sat    = |(scaled >> tune);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            tuning_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.ce && (state == DONE)) begin
                valid_q <= 1'b1;
                if (no_edge) begin
                    tuning_q   <= '0;
                    overflow_q <= 1'b1;
                end else if (sat) begin
                    tuning_q   <= '1;
                    overflow_q <= 1'b1;
                end else begin
                    tuning_q   <= scaled[tune-1:0];
                    overflow_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.valid      = valid_q;
    assign bus.tuning_out = tuning_q;
    assign bus.overflow   = overflow_q;
    assign dbg_state      = state;
endmodule
